regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers, x0..x31).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  write request from requester 0 (ALU writeback) and requester 1 (load/debug).
REQ-006 The block SHALL have ports req0_addr / req1_addr  input  ADDR_W  destination register of each request.
REQ-007 The block SHALL have ports req0_data / req1_data  input  DATA_W  write data of each request.
REQ-008 The block SHALL have ports req0_ready / req1_ready  output  1  combinational grant; a transfer occurs on a rising edge where valid and ready are both 1.
REQ-009 The block SHALL have port rf_we  output  1  registered write enable to the register file write port.
REQ-010 The block SHALL have port rf_waddr  output  ADDR_W  registered write address.
REQ-011 The block SHALL have port rf_wdata  output  DATA_W  registered write data.
REQ-012 The block SHALL have port init_done  output  1  registered; 1 once the post-reset clear sequence has completed.

Function
REQ-013 The FSM SHALL have two states: CLEAR (zero-fill of x1..x31) and ARB (normal arbitration).
REQ-014 In CLEAR, a 5-bit counter clr_cnt SHALL start at 1, and every rising edge SHALL register rf_we=1, rf_waddr=clr_cnt, rf_wdata=0, then increment clr_cnt.
REQ-015 On the edge that registers clr_cnt=31, the FSM SHALL move to ARB and set init_done=1; the clear SHALL take exactly 31 cycles, and x0 is never addressed.
REQ-016 In CLEAR, req0_ready and req1_ready SHALL be 0 regardless of valid.
REQ-017 In ARB with exactly one valid requester, that requester's ready SHALL be 1 and the other's SHALL be 0.
REQ-018 In ARB with both valid, the grant SHALL go to the requester named by a 1-bit round-robin pointer prio (0 = req0, 1 = req1); the loser's ready SHALL be 0.
REQ-019 After every transfer, prio SHALL point to the requester that was not granted; with no transfer, prio SHALL hold.
REQ-020 On a transfer edge, the block SHALL register rf_waddr and rf_wdata from the granted requester, giving one-cycle latency from handshake to the register-file write.
REQ-021 On a transfer edge, rf_we SHALL be set to 1 only if the granted address is nonzero; a write to x0 is accepted (ready=1) but produces rf_we=0.
REQ-022 On an ARB edge with no transfer, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL hold their previous values.
REQ-023 At most one transfer SHALL occur per cycle; sustained throughput is one write per cycle.
REQ-024 A requester SHALL keep valid, addr and data stable until its transfer, and a denied requester SHALL be granted within 2 cycles.
REQ-025 ready SHALL depend only on the valid inputs, prio and state, never on addr or data.

Reset
REQ-026 When rst=1, the block SHALL immediately enter CLEAR and set clr_cnt=1, prio=0, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, with both ready outputs 0.
REQ-027 A reset asserted mid-CLEAR or mid-ARB SHALL abort the operation in progress, drop any pending grant, and restart the full 31-cycle clear after release.
REQ-028 After reset release, the first rising edge SHALL register rf_we=1, rf_waddr=1, rf_wdata=0.

Verification
REQ-029 Release rst and hold all valids at 0 -> rf_we=1 for 31 consecutive edges with rf_waddr 1..31 and rf_wdata=0, then init_done=1 and rf_we=0.
REQ-030 Assert req0_valid during CLEAR with addr=1 and data=32'h12345678 -> req0_ready=0 until init_done, transfer on the first ARB cycle, next cycle rf_we=1, rf_waddr=1, rf_wdata=32'h12345678.
REQ-031 Hold both valid continuously in ARB with prio=0, req0 addr 1 and req1 addr 2 -> grants alternate 0,1,0,1, and rf_waddr alternates 1,2,1,2 with rf_we=1 every cycle.
REQ-032 req1 writes addr=0 with data=32'hABCDEF01 -> req1_ready=1, next cycle rf_we=0, and prio flips to 0.
REQ-033 Assert rst for 1 cycle during an ARB transfer -> rf_we=0 and init_done=0 immediately, and the 31-cycle clear repeats from address 1.
REQ-034 Only req1 is valid for 3 cycles -> 3 back-to-back transfers, and prio=0 after each.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-port write arbiter for the integer register file.
// Zero-fills x1..x31 after reset, then round-robins two writers.
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic {
    CLEAR,
    ARB
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] clrCntNext;
  logic              prio;
  logic              prioNext;
  logic              weNext;
  logic [ADDR_W-1:0] waddrNext;
  logic [DATA_W-1:0] wdataNext;
  logic              initNext;

  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic [ADDR_W-1:0] gntAddr;
  logic [DATA_W-1:0] gntData;

  // Grants look only at valids, prio and state.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ARB && !rst) begin
      gnt0 = req0_valid & (~req1_valid | ~prio);
      gnt1 = req1_valid & (~req0_valid | prio);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign gntAddr    = gnt1 ? req1_addr : req0_addr;
  assign gntData    = gnt1 ? req1_data : req0_data;

  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    prioNext   = prio;
    weNext     = 1'b0;
    waddrNext  = rf_waddr;
    wdataNext  = rf_wdata;
    initNext   = init_done;
    unique case (state)
      CLEAR: begin
        weNext     = 1'b1;
        waddrNext  = clrCnt;
        wdataNext  = '0;
        clrCntNext = clrCnt + 1'b1;
        if (&clrCnt) begin
          stateNext = ARB;
          initNext  = 1'b1;
        end
      end
      ARB: begin
        if (xfer) begin
          // x0 writes are accepted but never reach the file.
          weNext    = |gntAddr;
          waddrNext = gntAddr;
          wdataNext = gntData;
          prioNext  = ~gnt1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clrCnt    <= ADDR_W'(1);
      prio      <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= stateNext;
      clrCnt    <= clrCntNext;
      prio      <= prioNext;
      rf_we     <= weNext;
      rf_waddr  <= waddrNext;
      rf_wdata  <= wdataNext;
      init_done <= initNext;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors,
// per-cycle model compare and hand-computed checks.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: clear phase is "writes done so far" (0..31);
  // arbitration picks the only valid one, else the one prio names.
  int          mClr;
  bit          mPrio;
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic        mInit;
  int          mWin;

  function automatic int winner(logic v0, logic v1, bit p);
    if (v0 && v1) return p ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  assign mWin = (rst || mClr < 31) ? -1 :
                winner(req0_valid, req1_valid, mPrio);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mClr  <= 0;
      mPrio <= 1'b0;
      mWe   <= 1'b0;
      mAddr <= '0;
      mData <= '0;
      mInit <= 1'b0;
    end else if (mClr < 31) begin
      mWe   <= 1'b1;
      mAddr <= 5'(mClr + 1);
      mData <= '0;
      mClr  <= mClr + 1;
      mInit <= (mClr == 30);
    end else if (mWin == 0) begin
      mWe   <= (req0_addr != 0);
      mAddr <= req0_addr;
      mData <= req0_data;
      mPrio <= 1'b1;
    end else if (mWin == 1) begin
      mWe   <= (req1_addr != 0);
      mAddr <= req1_addr;
      mData <= req1_data;
      mPrio <= 1'b0;
    end else begin
      mWe <= 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    chk("we", 32'(rf_we), 32'(mWe));
    chk("waddr", 32'(rf_waddr), 32'(mAddr));
    chk("wdata", rf_wdata, mData);
    chk("init_done", 32'(init_done), 32'(mInit));
    chk("ready0", 32'(req0_ready), 32'(mWin == 0));
    chk("ready1", 32'(req1_ready), 32'(mWin == 1));
    if (rf_we === 1'b1) chk("no_x0_write", 32'(rf_waddr != 0), 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0;
    req0_addr = '0;
    req0_data = '0;
    req1_valid = 1'b0;
    req1_addr = '0;
    req1_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_init", 32'(init_done), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);

    // Clear with no requests.
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("pre_clr_we", 32'(rf_we), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("clr_addr", 32'(rf_waddr), 32'(i));
      chk("clr_we", 32'(rf_we), 32'd1);
      chk("clr_data", rf_wdata, 32'd0);
      chk("clr_init", 32'(init_done), 32'(i == 31));
    end
    @(negedge clk);
    chk("post_clr_we", 32'(rf_we), 32'd0);
    chk("post_clr_init", 32'(init_done), 32'd1);

    // Both valid: alternate grants.
    step();
    req0_valid = 1'b1;
    req0_addr = 5'd1;
    req0_data = 32'hA0A0_0001;
    req1_valid = 1'b1;
    req1_addr = 5'd2;
    req1_data = 32'hB0B0_0002;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_ready0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("alt_ready1", 32'(req1_ready), 32'(k % 2 == 1));
      if (k > 0) begin
        chk("alt_waddr", 32'(rf_waddr), (k % 2 == 1) ? 32'd1 : 32'd2);
        chk("alt_we", 32'(rf_we), 32'd1);
      end
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("alt_last_waddr", 32'(rf_waddr), 32'd2);
    chk("alt_last_data", rf_wdata, 32'hB0B0_0002);

    // req0 once (prio -> 1), then req1 to x0 (prio -> 0).
    step();
    req0_valid = 1'b1;
    req0_addr = 5'd5;
    req0_data = 32'h5555_5555;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_addr = 5'd0;
    req1_data = 32'hABCDEF01;
    @(negedge clk);
    chk("x0_ready1", 32'(req1_ready), 32'd1);
    step();
    req0_valid = 1'b1;
    req0_addr = 5'd6;
    req0_data = 32'h6666_6666;
    req1_valid = 1'b1;
    req1_addr = 5'd7;
    req1_data = 32'h7777_7777;
    @(negedge clk);
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_prio_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("fair_ready1", 32'(req1_ready), 32'd1);
    chk("fair_waddr", 32'(rf_waddr), 32'd6);
    step();
    req1_valid = 1'b0;

    // req1 alone, three back-to-back transfers.
    for (int j = 0; j < 3; j++) begin
      req1_valid = 1'b1;
      req1_addr = 5'(j + 3);
      req1_data = 32'hC000_0000 + 32'(j);
      @(negedge clk);
      chk("solo_ready1", 32'(req1_ready), 32'd1);
      step();
    end
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_addr = 5'd9;
    req0_data = 32'h9999_9999;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("solo_waddr", 32'(rf_waddr), 32'd5);
    chk("solo_prio_ready0", 32'(req0_ready), 32'd1);
    step();
    req1_valid = 1'b0;

    // Reset during a transfer; request held through the clear.
    @(negedge clk);
    chk("pre_rst_ready0", 32'(req0_ready), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_init", 32'(init_done), 32'd0);
    chk("midrst_ready0", 32'(req0_ready), 32'd0);
    req0_addr = 5'd1;
    req0_data = 32'h12345678;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready0", 32'(req0_ready), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("clr2_addr", 32'(rf_waddr), 32'(i));
      chk("clr2_ready0", 32'(req0_ready), 32'(i == 31));
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("first_we", 32'(rf_we), 32'd1);
    chk("first_waddr", 32'(rf_waddr), 32'd1);
    chk("first_wdata", rf_wdata, 32'h12345678);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
